// File: rtl/fpu_ftoi_seq.sv
// ============================================================================
// Module   : fpu_ftoi_seq
// Purpose  : Multi-cycle IEEE-754 single to int32 converter with saturation,
//            iterative right-shift alignment and valid/ready handshakes.
//            Optional macro FPU_FTOI_RNE_EN selects round-to-nearest-even
//            (default build: round-toward-zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_ftoi_seq #(
    parameter int unsigned C_SHIFT_STEP = 8
) (
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Flush_SI,
    input  logic        In_valid_SI,
    output logic        In_ready_SO,
    input  logic [31:0] Operand_a_DI,
    output logic        Out_valid_SO,
    input  logic        Out_ready_SI,
    output logic [31:0] Result_DO,
    output logic        Invalid_SO,
    output logic        Inexact_SO
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [5:0] C_STEP   = 6'(C_SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [5:0]  n_q, n_d;
    logic        guard_q, guard_d, sticky_q, sticky_d, sign_q, sign_d;
    logic        special_q, special_d, spec_inv_q, spec_inv_d, spec_inx_q, spec_inx_d;
    logic [31:0] result_q, result_d;
    logic        invalid_q, invalid_d, inexact_q, inexact_d, out_valid_q, out_valid_d;

    logic        w_op_sign, w_op_nan, w_op_big, w_op_minint, w_op_tiny, w_accept;
    logic [7:0]  w_op_exp;
    logic [22:0] w_op_man;
    logic [31:0] w_sat_val;
    logic [5:0]  w_shift_k, w_n_rem;
    logic [63:0] w_ext;
    logic        w_round_inc;
    logic [31:0] w_round, w_signed;

    assign w_op_sign   = Operand_a_DI[31];
    assign w_op_exp    = Operand_a_DI[30:23];
    assign w_op_man    = Operand_a_DI[22:0];
    assign w_op_nan    = (w_op_exp == 8'd255) && (w_op_man != 23'd0);
    // Biased exponent 158 is e=31: beyond int32 range except for exactly -2^31.
    assign w_op_big    = (w_op_exp >= 8'd158);
    assign w_op_minint = w_op_sign && (w_op_exp == 8'd158) && (w_op_man == 23'd0);
    assign w_op_tiny   = (w_op_exp < 8'd126);
    assign w_sat_val   = (w_op_nan || !w_op_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
    assign w_accept    = (state_q == ST_IDLE) && In_valid_SI && !Flush_SI;

    // Upper half is the shifted word, lower half holds the bits shifted out.
    assign w_shift_k = (n_q < C_STEP) ? n_q : C_STEP;
    assign w_ext     = {w_q, 32'd0} >> w_shift_k;
    assign w_n_rem   = n_q - w_shift_k;

`ifdef FPU_FTOI_RNE_EN
    assign w_round_inc = guard_q && (sticky_q || w_q[0]);
`else
    assign w_round_inc = 1'b0;
`endif
    assign w_round  = w_q + {31'd0, w_round_inc};
    assign w_signed = sign_q ? (32'd0 - w_round) : w_round;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= ST_IDLE;
            w_q         <= 32'd0;
            n_q         <= 6'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            special_q   <= 1'b0;
            spec_inv_q  <= 1'b0;
            spec_inx_q  <= 1'b0;
            result_q    <= 32'd0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            n_q         <= n_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            special_q   <= special_d;
            spec_inv_q  <= spec_inv_d;
            spec_inx_q  <= spec_inx_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = (w_op_big || w_op_tiny) ? ST_ROUND : ST_ALIGN;
            ST_ALIGN: if (w_n_rem == 6'd0) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (Out_ready_SI) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (Flush_SI) state_d = ST_IDLE;
    end

    always_comb begin
        w_d         = w_q;
        n_d         = n_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        special_d   = special_q;
        spec_inv_d  = spec_inv_q;
        spec_inx_d  = spec_inx_q;
        result_d    = result_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    sign_d   = w_op_sign;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    n_d      = 6'd0;
                    if (w_op_big) begin
                        special_d  = 1'b1;
                        w_d        = w_op_minint ? 32'h8000_0000 : w_sat_val;
                        spec_inv_d = !w_op_minint;
                        spec_inx_d = 1'b0;
                    end else if (w_op_tiny) begin
                        special_d  = 1'b1;
                        w_d        = 32'd0;
                        spec_inv_d = 1'b0;
                        spec_inx_d = |Operand_a_DI[30:0];
                    end else begin
                        special_d  = 1'b0;
                        spec_inv_d = 1'b0;
                        spec_inx_d = 1'b0;
                        w_d        = {1'b1, w_op_man, 8'd0};
                        n_d        = 6'(8'd158 - w_op_exp);
                    end
                end
            end
            ST_ALIGN: begin
                w_d      = w_ext[63:32];
                guard_d  = w_ext[31];
                sticky_d = sticky_q | guard_q | (|w_ext[30:0]);
                n_d      = w_n_rem;
            end
            ST_ROUND: begin
                if (special_q) begin
                    result_d  = w_q;
                    invalid_d = spec_inv_q;
                    inexact_d = spec_inx_q;
                end else begin
                    result_d  = w_signed;
                    invalid_d = 1'b0;
                    inexact_d = guard_q | sticky_q;
                end
                out_valid_d = 1'b1;
            end
            ST_DONE: if (Out_ready_SI) out_valid_d = 1'b0;
            default: out_valid_d = 1'b0;
        endcase
        if (Flush_SI) begin
            out_valid_d = 1'b0;
            invalid_d   = 1'b0;
            inexact_d   = 1'b0;
        end
    end

    always_comb begin
        In_ready_SO  = (state_q == ST_IDLE);
        Out_valid_SO = out_valid_q;
        Result_DO    = result_q;
        Invalid_SO   = invalid_q;
        Inexact_SO   = inexact_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_ftoi_seq.sv
// ============================================================================
// Module   : tb_fpu_ftoi_seq
// Purpose  : Scoreboard bench for fpu_ftoi_seq with directed vectors
//            (expectations follow FPU_FTOI_RNE_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_ftoi_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } exp_t;
    exp_t sb[$];

    fpu_ftoi_seq #(.C_SHIFT_STEP(8)) dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .Flush_SI     (flush),
        .In_valid_SI  (in_valid),
        .In_ready_SO  (in_ready),
        .Operand_a_DI (operand),
        .Out_valid_SO (out_valid),
        .Out_ready_SI (out_ready),
        .Result_DO    (result),
        .Invalid_SO   (invalid),
        .Inexact_SO   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("flags", {30'd0, invalid, inexact}, {30'd0, e.inv, e.inx});
            end
        end
    end

    // Latency counts rising edges from the accept edge (as 1) up to the edge raising Out_valid.
    task automatic run_op(input logic [31:0] op, input logic [31:0] res, input logic inv,
                          input logic inx, input int lat_req, input bit hold);
        int waitc = 0;
        int lat;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        operand  = op;
        in_valid = 1'b1;
        sb.push_back('{res, inv, inx});
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(lat_req));
        if (hold) begin
            check("hold_in_ready", 32'(in_ready), 32'd0);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_result", result, res);
                check("hold_flags", {30'd0, invalid, inexact}, {30'd0, inv, inx});
            end
            out_ready = 1'b1;
            check("release_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, invalid, inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 6, 1'b0); // 1.0
        run_op(32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 6, 1'b0); // -1.0
        run_op(32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 6, 1'b0); // -3.14159
        run_op(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0); // 2^31
        run_op(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 1'b0); // -2^31
        run_op(32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2, 1'b0);
        run_op(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0); // NaN
        run_op(32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0); // negative NaN
        run_op(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2, 1'b0); // -inf
        run_op(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0); // +inf
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2, 1'b0); // +0
        run_op(32'h3E80_0000, 32'h0000_0000, 1'b0, 1'b1, 2, 1'b0); // 0.25
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2, 1'b0); // denormal
        run_op(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 3, 1'b0); // largest e=30
        run_op(32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 3, 1'b0);
        run_op(32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 6, 1'b0); // 2.5
        run_op(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 6, 1'b0); // 0.5
`ifdef FPU_FTOI_RNE_EN
        run_op(32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1, 6, 1'b0); // 1.5
        run_op(32'h3F40_0000, 32'h0000_0001, 1'b0, 1'b1, 6, 1'b0); // 0.75
        run_op(32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 6, 1'b0); // -0.75
`else
        run_op(32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 6, 1'b0);
        run_op(32'h3F40_0000, 32'h0000_0000, 1'b0, 1'b1, 6, 1'b0);
        run_op(32'hBF40_0000, 32'h0000_0000, 1'b0, 1'b1, 6, 1'b0);
`endif

        // Back-pressure on 2.5
        out_ready = 1'b0;
        run_op(32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 6, 1'b1);

        // Flush during the second ALIGN cycle of 1.0; nothing is queued for it
        operand  = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid) seen++;
                @(posedge clk); #1;
            end
            check("flush_no_valid", 32'(seen), 32'd0);
        end

        // Flush together with In_valid in IDLE must not accept
        operand  = 32'h3F80_0000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_no_accept", 32'(in_ready), 32'd1);

        run_op(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 6, 1'b0); // 10.0

        // Asynchronous reset mid-ALIGN
        operand  = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_flags", {30'd0, invalid, inexact}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 6, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
